mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage, directly upstream of the write-back stage.
- Takes the EX result and control, performs data-memory load/store with RISC-V style byte/half/word sizing, and registers results into the MEM/WB pipeline register.
- Its outputs mem_to_reg, data_from_mem and data_from_ALU feed the write-back mux.
- Supports a configurable multi-cycle memory latency via a stall handshake.

Parameters:
- DEPTH_WORDS, 1024: data memory size in 32-bit words; power of two.
- MEM_LATENCY, 1: cycles per load/store access; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- valid_in  in  1  instruction present from EX
- mem_read  in  1  load
- mem_write  in  1  store; never high together with mem_read
- mem_to_reg_in  in  1  WB select, passed through
- reg_write_in  in  1  register write enable, passed through
- rd_in  in  5  destination register, passed through
- alu_result  in  32  byte address for loads/stores; ALU value otherwise
- store_data  in  32  rs2 value for stores
- funct3  in  3  access size/sign
- stall_out  out  1  upstream must hold all inputs while high
- valid_out  out  1  MEM/WB register holds a valid instruction
- mem_to_reg  out  1  registered
- reg_write_out  out  1  registered; forced 0 on misaligned access
- rd_out  out  5  registered
- data_from_mem  out  32  registered, extended load data
- data_from_ALU  out  32  registered alu_result
- misaligned  out  1  registered; access was misaligned and suppressed

Behaviour:
- Reset is asynchronous: all outputs 0, FSM in IDLE, counter 0. Memory contents are not reset.
- FSM states are IDLE and BUSY. stall_out = (state == BUSY), combinational from state only.
- IDLE, valid_in=0: next edge loads a bubble (valid_out=0, reg_write_out=0, other outputs hold).
- IDLE, valid_in=1, non-memory op: next edge registers the pass-through fields, valid_out=1, data_from_mem=0.
- IDLE, memory op, MEM_LATENCY=1:
  - Store commits at the accept edge.
  - Load data is registered at the accept edge.
  - valid_out=1 after that edge; no stall.
- IDLE, memory op, MEM_LATENCY=N>1:
  - At the accept edge, inputs are captured into hold registers, counter = N-2, state = BUSY, and a bubble is loaded into MEM/WB.
  - In BUSY with counter>0: decrement; valid_in is ignored.
  - In BUSY with counter==0: the access completes at that edge, storing or registering load data. MEM/WB gets the result with valid_out=1, and state returns to IDLE.
  - Total: result visible N edges after accept, with N-1 stall cycles.
- Addressing:
  - Word index = alu_result[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so addresses wrap modulo the memory size.
- funct3 decode:
  - Loads: 000 LB (sign), 001 LH (sign), 010 LW, 100 LBU (zero), 101 LHU (zero).
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code behaves as a word access.
  - Byte lane is addr[1:0]; half lane is addr[1].
- Misaligned access (half with addr[0]=1, word with addr[1:0]!=0):
  - No memory write; data_from_mem=0; misaligned=1; reg_write_out=0; valid_out=1.
  - Latency is unchanged.
- Reset during BUSY aborts the access. A pending store is never committed, because stores commit only at the completion edge.

Optional Feature:
- MEM_SUBWORD_EN defined: full byte/half support as above.
- Not defined: funct3 is ignored, and every access is a word access with only the word misalignment check. Byte-lane logic and the extension logic are removed.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state typedef mem_state_t {IDLE, BUSY}
  - XLEN=32 and REG_ADDR_W=5
- Sub-module data_mem_ram:
  - DEPTH_WORDS x 32 array with combinational read and synchronous write using a 4-bit byte enable.
  - The stage computes the byte enables and performs load extension.

Test Plan:
- MEM_LATENCY=1: SW 0xDEADBEEF to 0x10, then LW 0x10 -> data_from_mem=0xDEADBEEF the cycle after accept; stall_out never 1.
- With MEM_SUBWORD_EN: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SH 0x1234 at address 0x11 -> misaligned=1, reg_write_out=0; a subsequent LW 0x10 still returns 0xDEADBEEF.
- MEM_LATENCY=4: LW accepted -> stall_out high for 3 cycles, valid_out=0 bubbles during the stall, result valid 4 edges after accept; the held next instruction is accepted on the first IDLE cycle.
- MEM_LATENCY=4: assert rst during the second BUSY cycle of an SW to 0x20 -> all outputs 0 immediately; a later LW 0x20 returns the old contents.
- Non-memory op with alu_result=0x55, rd_in=7, reg_write_in=1 -> next cycle data_from_ALU=0x55, rd_out=7, reg_write_out=1, valid_out=1, mem_to_reg=0.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the MEM pipeline stage:
//               funct3 access codes, FSM state type, request/MEM-WB records
//               and the load sign/zero extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Everything the stage needs to finish an access, as presented by EX
  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       wdata;
    logic [2:0]            funct3;
  } mem_req_t;

  // Contents of the MEM/WB pipeline register
  typedef struct packed {
    logic                  valid;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data_mem;
    logic [XLEN-1:0]       data_alu;
    logic                  misaligned;
  } memwb_t;

  // Select the addressed byte/half of a loaded word and sign/zero extend it.
  // Codes that are not byte or half loads return the whole word.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      f3,
                                                  input logic [1:0]      lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'd0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ram.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ram
// Description : DEPTH_WORDS x 32 data memory, combinational read and
//               synchronous byte-enabled write. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  assign rdata_o = mem_q[addr_i];

  // Write only the byte lanes whose enable is set
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage. Performs data-memory loads/stores with
//               byte/half/word sizing, multi-cycle latency via stall_out, and
//               registers results into the MEM/WB pipeline register.
//               Build option MEM_SUBWORD_EN: byte/half accesses decoded from
//               funct3; without it every access is a word access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       store_data,
  input  logic [2:0]            funct3,
  output logic                  stall_out,
  output logic                  valid_out,
  output logic                  mem_to_reg,
  output logic                  reg_write_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [XLEN-1:0]       data_from_mem,
  output logic [XLEN-1:0]       data_from_ALU,
  output logic                  misaligned
);

  localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
  // BUSY lasts MEM_LATENCY-1 cycles; the counter reaches 0 on the last one
  localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

  mem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  mem_req_t   hold_q, hold_d;
  memwb_t     wb_q, wb_d;

  mem_req_t        w_in_req, w_sel;
  memwb_t          w_result;
  logic            w_is_mem, w_mis, w_access;
  logic [3:0]      w_be, w_ram_be;
  logic [XLEN-1:0] w_wdata, w_rdata, w_load;

  assign w_in_req = '{mem_read: mem_read, mem_write: mem_write, mem_to_reg: mem_to_reg_in,
                      reg_write: reg_write_in, rd: rd_in, addr: alu_result,
                      wdata: store_data, funct3: funct3};

  // While BUSY the captured request drives the access, not the (ignored) inputs
  assign w_sel    = (state_q == BUSY) ? hold_q : w_in_req;
  assign w_is_mem = w_sel.mem_read | w_sel.mem_write;
  assign w_access = (state_q == IDLE) ? (valid_in && w_is_mem && (MEM_LATENCY == 1))
                                      : (cnt_q == 4'd0);
  assign stall_out = (state_q == BUSY);

`ifdef MEM_SUBWORD_EN
  logic w_is_byte, w_is_half;
  // LBU/LHU codes only mean byte/half for loads; as store codes they are word
  assign w_is_byte = (w_sel.funct3 == F3_B) || (w_sel.mem_read && (w_sel.funct3 == F3_BU));
  assign w_is_half = (w_sel.funct3 == F3_H) || (w_sel.mem_read && (w_sel.funct3 == F3_HU));
  assign w_load    = load_extend(w_rdata, w_sel.funct3, w_sel.addr[1:0]);
`else
  logic w_unused_f3;
  assign w_unused_f3 = ^w_sel.funct3;
  assign w_load      = w_rdata;
`endif

  // Byte enables, lane-replicated write data and alignment check
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_sel.wdata;
    w_mis   = (w_sel.addr[1:0] != 2'b00);
`ifdef MEM_SUBWORD_EN
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_sel.addr[1:0];
      w_wdata = {4{w_sel.wdata[7:0]}};
      w_mis   = 1'b0;
    end else if (w_is_half) begin
      w_be    = w_sel.addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{w_sel.wdata[15:0]}};
      w_mis   = w_sel.addr[0];
    end
`endif
  end

  // Stores commit only on the completing edge and never when misaligned
  assign w_ram_be = (w_access && w_sel.mem_write && !w_mis) ? w_be : 4'b0000;

  data_mem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .addr_i (w_sel.addr[ADDR_W+1:2]),
    .be_i   (w_ram_be),
    .wdata_i(w_wdata),
    .rdata_o(w_rdata)
  );

  // Completed-instruction record for MEM/WB (also covers non-memory ops)
  always_comb begin
    w_result            = '0;
    w_result.valid      = 1'b1;
    w_result.mem_to_reg = w_sel.mem_to_reg;
    w_result.reg_write  = w_sel.reg_write & ~(w_is_mem & w_mis);
    w_result.rd         = w_sel.rd;
    w_result.data_mem   = (w_sel.mem_read && !w_mis) ? w_load : '0;
    w_result.data_alu   = w_sel.addr;
    w_result.misaligned = w_is_mem & w_mis;
  end

  // Next-state, latency counter, hold capture and MEM/WB load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wb_d    = wb_q;
    case (state_q)
      IDLE: begin
        if (!valid_in) begin
          wb_d.valid     = 1'b0;
          wb_d.reg_write = 1'b0;
        end else if (w_is_mem && (MEM_LATENCY > 1)) begin
          hold_d         = w_in_req;
          cnt_d          = CNT_INIT;
          state_d        = BUSY;
          wb_d.valid     = 1'b0;
          wb_d.reg_write = 1'b0;
        end else begin
          wb_d = w_result;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d          = cnt_q - 4'd1;
          wb_d.valid     = 1'b0;
          wb_d.reg_write = 1'b0;
        end else begin
          wb_d    = w_result;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hold_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wb_q    <= wb_d;
    end
  end

  assign valid_out     = wb_q.valid;
  assign mem_to_reg    = wb_q.mem_to_reg;
  assign reg_write_out = wb_q.reg_write;
  assign rd_out        = wb_q.rd;
  assign data_from_mem = wb_q.data_mem;
  assign data_from_ALU = wb_q.data_alu;
  assign misaligned    = wb_q.misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. One instance with
//               MEM_LATENCY=1 runs a vector table; one with MEM_LATENCY=4
//               runs stall, hold-and-accept and reset-abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

`ifdef MEM_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  typedef struct packed {
    logic        v;
    logic        rd_en;
    logic        wr_en;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        e_rw;
    logic [31:0] e_dmem;
    logic        e_mis;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] dmem;
    logic [31:0] dalu;
    logic        mis;
    logic        stall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, b_rst;
  vec_t a_in, b_in;
  logic        a_stall, a_valid, a_m2r, a_rw, a_mis;
  logic [4:0]  a_rd;
  logic [31:0] a_dmem, a_dalu;
  logic        b_stall, b_valid, b_m2r, b_rw, b_mis;
  logic [4:0]  b_rd;
  logic [31:0] b_dmem, b_dalu;

  mem_access_stage #(.DEPTH_WORDS(1024), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(a_rst), .valid_in(a_in.v), .mem_read(a_in.rd_en), .mem_write(a_in.wr_en),
    .mem_to_reg_in(a_in.m2r), .reg_write_in(a_in.rw), .rd_in(a_in.rd), .alu_result(a_in.addr),
    .store_data(a_in.wdata), .funct3(a_in.f3), .stall_out(a_stall), .valid_out(a_valid),
    .mem_to_reg(a_m2r), .reg_write_out(a_rw), .rd_out(a_rd), .data_from_mem(a_dmem),
    .data_from_ALU(a_dalu), .misaligned(a_mis));

  mem_access_stage #(.DEPTH_WORDS(1024), .MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(b_rst), .valid_in(b_in.v), .mem_read(b_in.rd_en), .mem_write(b_in.wr_en),
    .mem_to_reg_in(b_in.m2r), .reg_write_in(b_in.rw), .rd_in(b_in.rd), .alu_result(b_in.addr),
    .store_data(b_in.wdata), .funct3(b_in.f3), .stall_out(b_stall), .valid_out(b_valid),
    .mem_to_reg(b_m2r), .reg_write_out(b_rw), .rd_out(b_rd), .data_from_mem(b_dmem),
    .data_from_ALU(b_dalu), .misaligned(b_mis));

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t last_a, last_b;
  exp_t zero_e;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic re, logic we, logic m2r, logic rw, logic [4:0] rd,
                              logic [31:0] addr, logic [31:0] wdata, logic [2:0] f3,
                              logic erw, logic [31:0] edm, logic emis);
    vec_t r;
    r = '{v: v, rd_en: re, wr_en: we, m2r: m2r, rw: rw, rd: rd, addr: addr, wdata: wdata,
          f3: f3, e_rw: erw, e_dmem: edm, e_mis: emis};
    return r;
  endfunction

  // Expected MEM/WB contents after an edge that sees v (bubbles hold other fields)
  function automatic exp_t exp_of(vec_t v, exp_t last);
    exp_t e;
    if (!v.v) begin
      e       = last;
      e.valid = 1'b0;
      e.rw    = 1'b0;
    end else begin
      e = '{valid: 1'b1, m2r: v.m2r, rw: v.e_rw, rd: v.rd, dmem: v.e_dmem, dalu: v.addr,
            mis: v.e_mis, stall: 1'b0};
    end
    e.stall = 1'b0;
    return e;
  endfunction

  function automatic exp_t act_a();
    return {a_valid, a_m2r, a_rw, a_rd, a_dmem, a_dalu, a_mis, a_stall};
  endfunction

  function automatic exp_t act_b();
    return {b_valid, b_m2r, b_rw, b_rd, b_dmem, b_dalu, b_mis, b_stall};
  endfunction

  task automatic cmp(input string nm, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%b m2r=%b rw=%b rd=%0d dmem=%h dalu=%h mis=%b stall=%b, expected valid=%b m2r=%b rw=%b rd=%0d dmem=%h dalu=%h mis=%b stall=%b",
               nm, act.valid, act.m2r, act.rw, act.rd, act.dmem, act.dalu, act.mis, act.stall,
               exp.valid, exp.m2r, exp.rw, exp.rd, exp.dmem, exp.dalu, exp.mis, exp.stall);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sb_check_a(input string nm);
    if (qa.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got output with empty scoreboard, expected a queued result", nm);
    end else cmp(nm, act_a(), qa.pop_front());
  endtask

  task automatic sb_check_b(input string nm);
    if (qb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got output with empty scoreboard, expected a queued result", nm);
    end else cmp(nm, act_b(), qb.pop_front());
  endtask

  // Latency-4 transaction: issue op a, then present nxt (held by upstream)
  // while the stage stalls; nxt must be taken on the first IDLE cycle.
  task automatic b_run(input vec_t a, input vec_t nxt, input string nm);
    int stalls;
    bit bad;
    @(negedge clk);
    b_in   = a;
    last_b = exp_of(a, last_b);
    qb.push_back(last_b);
    @(posedge clk); #1;
    b_in   = nxt;
    last_b = exp_of(nxt, last_b);
    if (nxt.v) qb.push_back(last_b);
    stalls = 0;
    bad    = 1'b0;
    while (b_stall && stalls < 20) begin
      stalls++;
      if (b_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk_int({nm, "_stall_cycles"}, stalls, 3);
    chk_int({nm, "_bubble_during_stall"}, int'(bad), 0);
    sb_check_b(nm);
    if (nxt.v) begin
      @(posedge clk); #1;
      sb_check_b({nm, "_next"});
    end
    b_in = '0;
  endtask

  initial begin
    a_in = '0; b_in = '0; a_rst = 1'b1; b_rst = 1'b1;
    zero_e = '0; last_a = '0; last_b = '0;

    //           v     re    we    m2r   rw    rd     addr          wdata         f3      e_rw  e_dmem                                e_mis
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h10,   32'hDEADBEEF, 3'b010, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'h10,   32'h0, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  32'h13,   32'h0, 3'b000, SUB, SUB ? 32'hFFFFFFDE : 32'h0, ~SUB));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  32'h13,   32'h0, 3'b100, SUB, SUB ? 32'h000000DE : 32'h0, ~SUB));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  32'h12,   32'h0, 3'b001, SUB, SUB ? 32'hFFFFDEAD : 32'h0, ~SUB));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  32'h10,   32'h0, 3'b101, 1'b1, SUB ? 32'h0000BEEF : 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  32'h10,   32'h0, 3'b000, 1'b1, SUB ? 32'hFFFFFFEF : 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  32'h11,   32'h1234, 3'b001, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'h10,   32'h0, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    32'h0, 3'b000, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'h55,   32'h0, 3'b000, 1'b1, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h20,   32'h11223344, 3'b010, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h21,   32'h000000A5, 3'b000, 1'b0, 32'h0, ~SUB));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  32'h20,   32'h0, 3'b010, 1'b1, SUB ? 32'h1122A544 : 32'h11223344, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h22,   32'hBBBB5A6B, 3'b001, 1'b0, 32'h0, ~SUB));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h20,   32'h0, 3'b010, 1'b1, SUB ? 32'h5A6BA544 : 32'h11223344, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'h1010, 32'h0, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h12,   32'h0, 3'b010, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h30,   32'hCAFEF00D, 3'b011, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h30,   32'h0, 3'b110, 1'b1, 32'hCAFEF00D, 1'b0));

    #2;
    cmp("reset_lat1", act_a(), zero_e);
    cmp("reset_lat4", act_b(), zero_e);
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Latency-1 instance: one vector per cycle, result right after accept
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      a_in   = tbl[i];
      last_a = exp_of(tbl[i], last_a);
      qa.push_back(last_a);
      @(posedge clk); #1;
      sb_check_a($sformatf("lat1_vec%0d", i));
    end
    @(negedge clk);
    a_in = '0;

    // Latency-4 instance
    b_run(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0, 1'b0),
          mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h77, 32'h0, 3'b000, 1'b1, 32'h0, 1'b0), "lat4_sw10");
    b_run(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h10, 32'h0, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0),
          mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h55, 32'h0, 3'b000, 1'b1, 32'h0, 1'b0), "lat4_lw10");
    b_run(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'h11223344, 3'b010, 1'b0, 32'h0, 1'b0),
          '0, "lat4_sw20");

    // Store to 0x20 aborted by reset in its second BUSY cycle
    @(negedge clk);
    b_in = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'h99999999, 3'b010, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    b_in = '0;
    @(posedge clk); #1;
    chk_int("abort_still_busy", int'(b_stall), 1);
    #1;
    b_rst = 1'b1;
    #1;
    cmp("abort_reset_outputs", act_b(), zero_e);
    @(negedge clk);
    b_rst  = 1'b0;
    last_b = '0;
    b_run(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h20, 32'h0, 3'b010, 1'b1, 32'h11223344, 1'b0),
          '0, "lat4_lw20_after_abort");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time limit, expected bench to finish");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
